// File: rtl/gcd_arbiter.sv
// ---------------------------------------------------------------------------
// gcd_arbiter
//
// Shares a single GCD engine among NUM_REQ requesters. A round-robin arbiter
// accepts one operand pair at a time and starts the engine. The block then
// waits for the engine's done pulse or for a watchdog timeout. The result is
// returned, tagged with the requester index, on one valid/ready response
// channel. If either operand is zero the engine is bypassed and the result is
// a|b, so gcd(x,0)=x and gcd(0,0)=0.
//
// Ports:
//   clk_i         clock, rising edge
//   nreset_i      asynchronous active-low reset
//   req_valid_i   per-requester request valid
//   req_a_i       operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b_i       operand B, same packing
//   req_ready_o   one-hot accept (idle state only)
//   eng_start_o   one-cycle engine start pulse
//   eng_a_o       operand A to engine (valid while issuing/waiting)
//   eng_b_o       operand B to engine (valid while issuing/waiting)
//   eng_abort_o   one-cycle engine abort pulse on timeout
//   eng_done_i    engine result valid pulse
//   eng_result_i  engine result, sampled with eng_done_i
//   rsp_valid_o   response valid
//   rsp_id_o      requester index of the response
//   rsp_result_o  GCD result (0 on timeout)
//   rsp_error_o   1 = engine timed out
//   rsp_ready_i   response consumer ready
// ---------------------------------------------------------------------------
module gcd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 256,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     nreset_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     eng_start_o,
    output logic [WIDTH-1:0]         eng_a_o,
    output logic [WIDTH-1:0]         eng_b_o,
    output logic                     eng_abort_o,
    input  logic                     eng_done_i,
    input  logic [WIDTH-1:0]         eng_result_i,
    output logic                     rsp_valid_o,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [WIDTH-1:0]         rsp_result_o,
    output logic                     rsp_error_o,
    input  logic                     rsp_ready_i
);

    localparam int              TMR_W     = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]    NUM_REQ_X = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [TMR_W-1:0]  timer_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [ID_W-1:0]   id_reg;
    logic [WIDTH-1:0]  result_reg;
    logic              error_reg;

    // Unpacked view of the per-requester operand buses.
    logic [WIDTH-1:0]  a_arr [NUM_REQ];
    logic [WIDTH-1:0]  b_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a_i[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search: walk rr_ptr, rr_ptr+1, ... (mod NUM_REQ) and take
    // the first valid requester. The index sum is one bit wider so the
    // wrap-around can be detected without a modulo operator.
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     scan_sum;
    logic [ID_W-1:0]   scan_sel;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_sel    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_reg} + (ID_W + 1)'(k);
            if (scan_sum >= NUM_REQ_X) begin
                scan_sum = scan_sum - NUM_REQ_X;
            end
            scan_sel = scan_sum[ID_W-1:0];
            if (!grant_found && req_valid_i[scan_sel]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sel;
            end
        end
    end

    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    assign a_sel = a_arr[grant_idx];
    assign b_sel = b_arr[grant_idx];

    // Accept is offered only while idle; a grant implies a valid request, so
    // a grant in S_IDLE is always a completed handshake. Reset forces it low
    // so every output is quiet while nreset_i is asserted.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready_o[gi] = nreset_i && (state_reg == S_IDLE) &&
                                     grant_found && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Timeout fires only when the engine has not answered in the last
    // permitted cycle; a simultaneous done takes priority.
    logic timeout_hit;
    assign timeout_hit = (state_reg == S_WAIT) && !eng_done_i && (timer_reg == TMR_LAST);

    assign eng_start_o  = (state_reg == S_ISSUE);
    assign eng_abort_o  = timeout_hit;
    assign eng_a_o      = (state_reg == S_ISSUE || state_reg == S_WAIT) ? a_reg : '0;
    assign eng_b_o      = (state_reg == S_ISSUE || state_reg == S_WAIT) ? b_reg : '0;
    assign rsp_valid_o  = (state_reg == S_RESP);
    assign rsp_id_o     = (state_reg == S_RESP) ? id_reg     : '0;
    assign rsp_result_o = (state_reg == S_RESP) ? result_reg : '0;
    assign rsp_error_o  = (state_reg == S_RESP) ? error_reg  : 1'b0;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_reg  <= S_IDLE;
            rr_ptr_reg <= '0;
            timer_reg  <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            id_reg     <= '0;
            result_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (grant_found) begin
                        a_reg  <= a_sel;
                        b_reg  <= b_sel;
                        id_reg <= grant_idx;
                        if (a_sel == '0 || b_sel == '0) begin
                            // Zero operand: answer directly, engine untouched.
                            result_reg <= a_sel | b_sel;
                            error_reg  <= 1'b0;
                            state_reg  <= S_RESP;
                        end else begin
                            state_reg  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    timer_reg <= '0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done_i) begin
                        result_reg <= eng_result_i;
                        error_reg  <= 1'b0;
                        state_reg  <= S_RESP;
                    end else if (timer_reg == TMR_LAST) begin
                        result_reg <= '0;
                        error_reg  <= 1'b1;
                        state_reg  <= S_RESP;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state_reg  <= S_IDLE;
                        rr_ptr_reg <= (id_reg == ID_LAST) ? '0 : id_reg + ID_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gcd_arbiter
//
// Self-checking bench for gcd_arbiter (NUM_REQ=4, WIDTH=16, TIMEOUT=8).
// A behavioural engine answers start pulses with the GCD after a chosen
// delay (0 = never answers). Directed vectors live in a table; randomized
// transactions are checked against a reference model built from round-robin
// pointer arithmetic, Euclid's algorithm and closed-form latencies.
// ---------------------------------------------------------------------------
module tb_gcd_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TMO  = 8;

    logic               clk = 1'b0;
    logic               nreset_i = 1'b1;
    logic [NREQ-1:0]    req_valid_i = '0;
    logic [NREQ*W-1:0]  req_a_i = '0;
    logic [NREQ*W-1:0]  req_b_i = '0;
    logic [NREQ-1:0]    req_ready_o;
    logic               eng_start_o;
    logic [W-1:0]       eng_a_o;
    logic [W-1:0]       eng_b_o;
    logic               eng_abort_o;
    logic               eng_done_i = 1'b0;
    logic [W-1:0]       eng_result_i = '0;
    logic               rsp_valid_o;
    logic [1:0]         rsp_id_o;
    logic [W-1:0]       rsp_result_o;
    logic               rsp_error_o;
    logic               rsp_ready_i = 1'b0;

    gcd_arbiter #(
        .NUM_REQ (NREQ),
        .WIDTH   (W),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i        (clk),
        .nreset_i     (nreset_i),
        .req_valid_i  (req_valid_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_ready_o  (req_ready_o),
        .eng_start_o  (eng_start_o),
        .eng_a_o      (eng_a_o),
        .eng_b_o      (eng_b_o),
        .eng_abort_o  (eng_abort_o),
        .eng_done_i   (eng_done_i),
        .eng_result_i (eng_result_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_error_o  (rsp_error_o),
        .rsp_ready_i  (rsp_ready_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle_cnt = 0;
    int model_ptr = 0;
    int eng_delay = 0;
    int start_cnt = 0, start_cyc = -1, abort_cnt = 0, abort_cyc = -1;
    int onehot_viol = 0;
    int txn_no = 0;
    logic [W-1:0] start_a = '0, start_b = '0;
    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] a;
        logic [15:0] b;
        int          delay;
        int          hold;
        int          exp_id;
        int          exp_res;
        int          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];

    // ---------------- reference helpers ----------------
    function automatic int gcd_ref(input int a, input int b);
        int x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    function automatic int pick(input logic [3:0] mask);
        int i;
        for (int k = 0; k < NREQ; k++) begin
            i = (model_ptr + k) % NREQ;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got no event, expected one within the cycle bound", name);
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // ---------------- clock-side processes ----------------
    initial forever begin
        @(posedge clk);
        cycle_cnt++;
    end

    // Engine model: start at cycle S yields done at S+delay; delay 0 never answers.
    initial begin
        int cnt;
        logic [W-1:0] pend;
        cnt = 0; pend = '0;
        forever begin
            @(negedge clk);
            eng_done_i   = 1'b0;
            eng_result_i = '0;
            if (!nreset_i) begin
                cnt = 0;
            end else if (eng_start_o) begin
                cnt  = eng_delay;
                pend = W'(gcd_ref(int'(eng_a_o), int'(eng_b_o)));
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_done_i   = 1'b1;
                    eng_result_i = pend;
                end
            end
        end
    end

    // Event monitor, sampled 1 time unit after the falling edge.
    initial forever begin
        @(negedge clk);
        #1;
        if (eng_start_o) begin
            start_cnt++; start_cyc = cycle_cnt; start_a = eng_a_o; start_b = eng_b_o;
        end
        if (eng_abort_o) begin
            abort_cnt++; abort_cyc = cycle_cnt;
        end
        if ($countones(req_ready_o) > 1) onehot_viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus tasks ----------------
    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a_i[i*W +: W] = op_a[i];
            req_b_i[i*W +: W] = op_b[i];
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ctl"}, {22'd0, rsp_valid_o, eng_start_o, eng_abort_o, req_ready_o, rsp_id_o, rsp_error_o}, 32'd0);
        chk({tag, "_eng_ab"}, {eng_a_o, eng_b_o}, 32'd0);
        chk({tag, "_result"}, rsp_result_o, 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        req_valid_i = '0;
        rsp_ready_i = 1'b0;
        nreset_i    = 1'b0;
        #1;
        check_quiet("reset_async");
        repeat (cycles) tick();
        check_quiet("reset_hold");
        nreset_i  = 1'b1;
        model_ptr = 0;
    endtask

    // One transaction: offer mask, expect grant exp_id, response after
    // exp_lat cycles, then hold backpressure for 'hold' extra cycles.
    task automatic do_txn(input logic [3:0] mask, input int delay, input int hold, input bit keep,
                          input int exp_id, input int exp_res, input int exp_err, input int exp_lat);
        int t_acc, t_rsp, s0, a0;
        bit stable;
        logic [W-1:0] ea, eb;
        ea = op_a[exp_id];
        eb = op_b[exp_id];
        eng_delay   = delay;
        pack_ops();
        req_valid_i = mask;
        rsp_ready_i = (hold == 0);
        s0 = start_cnt;
        a0 = abort_cnt;
        #1;
        t_acc = -1;
        for (int c = 0; c < 20; c++) begin
            if ((req_ready_o & mask) != 0) begin
                t_acc = cycle_cnt;
                break;
            end
            tick();
        end
        if (t_acc < 0) begin
            fail_bound("accept");
            req_valid_i = '0;
            return;
        end
        chk("grant", {28'd0, req_ready_o}, 32'd1 << exp_id);
        tick();
        if (!keep) req_valid_i = '0;
        for (int c = 0; c < 40 && !rsp_valid_o; c++) tick();
        if (!rsp_valid_o) begin
            fail_bound("response");
            req_valid_i = '0;
            rsp_ready_i = 1'b1;
            return;
        end
        t_rsp = cycle_cnt;
        chk("rsp_id", {30'd0, rsp_id_o}, exp_id);
        chk("rsp_result", {16'd0, rsp_result_o}, exp_res);
        chk("rsp_error", {31'd0, rsp_error_o}, exp_err);
        chk("latency", t_rsp - t_acc, exp_lat);
        chk("ready_busy", {28'd0, req_ready_o}, 32'd0);
        $display("txn %0d: mask=%b id=%0d a=%0d b=%0d -> result=%0d error=%0d latency=%0d hold=%0d",
                 txn_no, mask, rsp_id_o, ea, eb, rsp_result_o, rsp_error_o, t_rsp - t_acc, hold);
        txn_no++;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (!rsp_valid_o || int'(rsp_id_o) != exp_id || int'(rsp_result_o) != exp_res ||
                int'(rsp_error_o) != exp_err || req_ready_o != '0) stable = 1'b0;
        end
        if (hold > 0) chk("bp_stable", {31'd0, stable}, 32'd1);
        rsp_ready_i = 1'b1;
        tick();
        chk("rsp_drop", {31'd0, rsp_valid_o}, 32'd0);
        chk("starts", start_cnt - s0, (exp_lat == 1) ? 0 : 1);
        if (exp_lat != 1) begin
            chk("start_cycle", start_cyc - t_acc, 32'd1);
            chk("start_ops", {start_a, start_b}, {ea, eb});
        end
        chk("aborts", abort_cnt - a0, exp_err);
        if (exp_err != 0) chk("abort_cycle", abort_cyc - t_acc, TMO + 1);
        model_ptr = (exp_id + 1) % NREQ;
    endtask

    // Model-driven transaction: expectations from the specification's rules.
    task automatic model_txn(input logic [3:0] mask, input int delay, input int hold, input bit keep);
        int id, a, b, res, err, lat;
        bit bypass;
        id = pick(mask);
        a = int'(op_a[id]);
        b = int'(op_b[id]);
        bypass = (a == 0) || (b == 0);
        err = (!bypass && (delay == 0 || delay > TMO)) ? 1 : 0;
        if (bypass)        begin res = (a == 0) ? b : a; lat = 1;         end
        else if (err != 0) begin res = 0;                 lat = TMO + 2;  end
        else               begin res = gcd_ref(a, b);     lat = delay + 2; end
        do_txn(mask, delay, hold, keep, id, res, err, lat);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{4'b0001, 16'd48,    16'd18,  5, 0, 0,   6, 0,  7};
        vecs[1] = '{4'b0010, 16'd0,     16'd35,  3, 0, 1,  35, 0,  1};
        vecs[2] = '{4'b0100, 16'd0,     16'd0,   3, 0, 2,   0, 0,  1};
        vecs[3] = '{4'b1000, 16'd100,   16'd0,   3, 0, 3, 100, 0,  1};
        vecs[4] = '{4'b0010, 16'd12,    16'd18,  0, 0, 1,   0, 1, 10};
        vecs[5] = '{4'b0100, 16'd21,    16'd14,  8, 0, 2,   7, 0, 10};
        vecs[6] = '{4'b0011, 16'd17,    16'd5,   1, 0, 0,   1, 0,  3};
        vecs[7] = '{4'b1001, 16'd65535, 16'd255, 2, 4, 3, 255, 0,  4};
        vecs[8] = '{4'b0100, 16'd1000,  16'd250, 9, 0, 2,   0, 1, 10};
        vecs[9] = '{4'b0111, 16'd9,     16'd6,   4, 0, 0,   3, 0,  6};
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        do_reset(3);

        // Directed table: pointer sequence 0->1->2->3->0->2->3->1->0->3->1.
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = vecs[v].a;
                op_b[i] = vecs[v].b;
            end
            do_txn(vecs[v].mask, vecs[v].delay, vecs[v].hold, 1'b0,
                   vecs[v].exp_id, vecs[v].exp_res, vecs[v].exp_err, vecs[v].exp_lat);
        end

        // Fairness: all requesters held valid from a fresh reset.
        do_reset(2);
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = W'(12 * (i + 1));
            op_b[i] = 16'd18;
        end
        for (int n = 0; n < 5; n++) begin
            chk("fair_order", pick(4'hF), (n == 4) ? 0 : n);
            model_txn(4'hF, 3, 0, n != 4);
        end

        // Backpressure with everyone pending, then the next grant is id+1.
        model_txn(4'hF, 3, 10, 1'b1);
        model_txn(4'hF, 2, 0, 1'b0);

        // Reset in the middle of S_WAIT.
        op_a[3] = 16'd30;
        op_b[3] = 16'd12;
        eng_delay = 0;
        pack_ops();
        req_valid_i = 4'b1000;
        rsp_ready_i = 1'b1;
        #1;
        chk("mid_grant", {28'd0, req_ready_o}, 32'h8);
        tick();
        req_valid_i = '0;
        tick();
        tick();
        chk("mid_wait_opa", {16'd0, eng_a_o}, 32'd30);
        nreset_i = 1'b0;
        #1;
        check_quiet("mid_reset");
        tick();
        nreset_i  = 1'b1;
        model_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 16'd8;
            op_b[i] = 16'd12;
        end
        model_txn(4'b1010, 2, 0, 1'b0);
        op_a[2] = 16'd27;
        op_b[2] = 16'd18;
        model_txn(4'b0100, 3, 0, 1'b0);

        // Randomized transactions against the reference model.
        for (int r = 0; r < 40; r++) begin
            int f;
            for (int i = 0; i < NREQ; i++) begin
                f = int'($urandom_range(1, 20));
                op_a[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : W'(f * int'($urandom_range(1, 200)));
                op_b[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : W'(f * int'($urandom_range(1, 200)));
            end
            model_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 10)),
                      int'($urandom_range(0, 3)), 1'b0);
        end

        chk("ready_onehot_all", onehot_viol, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one GCD engine among NUM_REQ requesters.
- Accepts an operand pair from one requester at a time, starts the engine, and waits for done or a watchdog timeout.
- Returns the result, tagged with the requester ID, on a single valid/ready response channel.
- Sits between client blocks and the GCD datapath/FSM. Zero operands bypass the engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 16, operand/result width in bits.
- TIMEOUT, 256, WAIT cycles before abort (>=2).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk_i  in  1  clock, rising edge.
- nreset_i  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_a_i  in  NUM_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b_i  in  NUM_REQ*WIDTH  operand B, same packing as req_a_i.
- req_ready_o  out  NUM_REQ  one-hot accept; at most one bit high.
- eng_start_o  out  1  one-cycle engine start pulse.
- eng_a_o  out  WIDTH  operand A to engine.
- eng_b_o  out  WIDTH  operand B to engine.
- eng_abort_o  out  1  one-cycle engine abort/reinit pulse.
- eng_done_i  in  1  engine result valid (pulse).
- eng_result_i  in  WIDTH  engine result; sampled when eng_done_i=1.
- rsp_valid_o  out  1  response valid.
- rsp_id_o  out  ID_W  requester index of response.
- rsp_result_o  out  WIDTH  GCD result.
- rsp_error_o  out  1  1 = timeout, result forced 0.
- rsp_ready_i  in  1  response consumer ready.

Behaviour:
- Reset (nreset_i=0, async): state S_IDLE; rr_ptr=0; timer=0; all outputs 0. Latched operands, ID and result cleared to 0.
- States: S_IDLE, S_ISSUE, S_WAIT, S_RESP. Encoding 2 bits; unused encoding returns to S_IDLE.
- Arbitration (S_IDLE only):
  - Grant = first index i with req_valid_i[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready_o is combinational: the grant bit, only in S_IDLE; all zero in other states.
  - Handshake = valid & ready. In the handshake cycle the block latches a, b and id.
- Next state from S_IDLE:
  - If a==0 or b==0: S_RESP with result = a|b, error=0. No engine activity, so gcd(x,0)=x and gcd(0,0)=0.
  - Otherwise: S_ISSUE.
- S_ISSUE: eng_start_o=1 for exactly one cycle; timer cleared; next S_WAIT.
- eng_a_o/eng_b_o: drive the latched operands from S_ISSUE through S_WAIT; 0 otherwise.
- S_WAIT: timer increments each cycle.
  - eng_done_i=1: capture eng_result_i, error=0, go to S_RESP.
  - Else if timer==TIMEOUT-1: eng_abort_o=1 for that cycle, result=0, error=1, go to S_RESP.
  - Done and timeout in the same cycle: done wins, no abort.
- S_RESP: rsp_valid_o=1. rsp_id_o, rsp_result_o and rsp_error_o stay stable until rsp_ready_i=1.
  - On handshake: next S_IDLE, rr_ptr = (id+1) mod NUM_REQ.
  - rsp_valid_o deasserts the next cycle.
- Latency, request accepted at cycle T:
  - Normal path: eng_start_o at T+1; engine done at cycle D gives rsp_valid_o at D+1.
  - Bypass path: rsp_valid_o at T+1.
- Throughput: one transaction in flight; the next accept is at the earliest the cycle after the response handshake.
- eng_done_i outside S_WAIT is ignored. req_valid_i changes outside S_IDLE have no effect.
- Reset mid-operation returns to the reset values immediately. The engine is not pulsed; it relies on the shared nreset_i.

Test Plan:
- Single request: NUM_REQ=4, req 0 a=48 b=18; engine model asserts done 5 cycles after start with 6 -> eng_start_o at T+1, rsp id=0 result=6 error=0 at done+1.
- Fairness: all 4 req_valid held high, engine answers in 3 cycles, rsp_ready_i=1 -> grant order 0,1,2,3,0; no requester starved.
- Zero bypass: a=0 b=35 -> rsp result=35 at T+1, no eng_start_o. a=0 b=0 -> result=0, error=0.
- Timeout: TIMEOUT=8, engine never done -> eng_abort_o on the 8th S_WAIT cycle; rsp error=1 result=0. Same-cycle done at timer=7 -> error=0, no abort.
- Backpressure: rsp_ready_i=0 for 10 cycles with other requests pending -> rsp fields stable, req_ready_o all 0; after release the next grant goes to id+1.
- Reset mid-S_WAIT: nreset_i low for 1 cycle -> all outputs 0 asynchronously, rr_ptr=0; the next request from requester 2 is granted normally.
